// File: rtl/avst_pkt_checker.sv
// Avalon-ST packet sink. It drains the packet FIFO read side, checks SOP/EOP
// framing, the incrementing-word payload, the error sideband and the packet
// length, and keeps saturating statistics counters. An optional LFSR drives
// pseudo-random backpressure on in_ready.
module avst_pkt_checker #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_BEATS = 2048,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_startofpacket,
  input  logic             in_endofpacket,
  input  logic [1:0]       in_empty,
  input  logic             in_error,
  input  logic             bp_en,
  input  logic             clear,
  output logic [CNT_W-1:0] good_pkts,
  output logic [CNT_W-1:0] bad_pkts,
  output logic [CNT_W-1:0] rx_bytes,
  output logic [CNT_W-1:0] framing_errs,
  output logic [CNT_W-1:0] data_errs,
  output logic             err_sticky
);

  localparam int unsigned       BEAT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] BEATS_MAX  = BEAT_W'(MAX_BEATS);
  localparam logic [BEAT_W-1:0] BEATS_LAST = BEAT_W'(MAX_BEATS - 1);

  typedef enum logic {
    S_IDLE,
    S_INPKT
  } state_t;

  state_t            r_state;
  logic [15:0]       r_lfsr;
  logic              r_ready;
  logic [31:0]       r_exp;
  logic [BEAT_W-1:0] r_beats;
  logic              r_pkt_err;

  logic [CNT_W-1:0]  r_good;
  logic [CNT_W-1:0]  r_bad;
  logic [CNT_W-1:0]  r_bytes;
  logic [CNT_W-1:0]  r_fram;
  logic [CNT_W-1:0]  r_data;
  logic              r_sticky;

  logic              w_acc;
  logic              w_lfsr_fb;
  logic [31:0]       w_mask;
  logic              w_mismatch;
  logic              w_good_inc;
  logic              w_bad_inc;
  logic              w_fram_inc;
  logic              w_data_inc;
  logic              w_overrun;
  logic              w_err_any;
  logic [2:0]        w_bytes_add;
  logic [CNT_W:0]    w_bytes_sum;
  logic [CNT_W-1:0]  w_bytes_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign w_acc      = in_valid & r_ready;
  assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_mask     = in_endofpacket ? ('1 << {in_empty, 3'b000}) : '1;
  assign w_mismatch = |((in_data ^ r_exp) & w_mask);

  // Per-beat event decode; a new SOP beat is never payload-compared, and each
  // counter sees at most one increment per beat even when events coincide.
  always_comb begin
    w_good_inc  = 1'b0;
    w_bad_inc   = 1'b0;
    w_fram_inc  = 1'b0;
    w_data_inc  = 1'b0;
    w_overrun   = 1'b0;
    w_bytes_add = 3'd0;
    if (w_acc) begin
      if ((r_state == S_IDLE) && !in_startofpacket) begin
        w_fram_inc = 1'b1;
      end else begin
        w_bytes_add = in_endofpacket ? (3'd4 - {1'b0, in_empty}) : 3'd4;
        if (in_startofpacket) begin
          if (r_state == S_INPKT) begin
            w_fram_inc = 1'b1;
            w_bad_inc  = 1'b1;
          end
          if (in_endofpacket) begin
            if (in_error) w_bad_inc  = 1'b1;
            else          w_good_inc = 1'b1;
          end
        end else begin
          w_data_inc = w_mismatch;
          w_overrun  = !in_endofpacket && (r_beats == BEATS_LAST);
          w_fram_inc = w_overrun;
          if (in_endofpacket) begin
            if (r_pkt_err || in_error || w_mismatch) w_bad_inc  = 1'b1;
            else                                      w_good_inc = 1'b1;
          end
        end
      end
    end
  end

  assign w_err_any = w_fram_inc | w_data_inc | w_bad_inc |
                     (w_acc & in_error & (in_startofpacket | (r_state == S_INPKT)));

  // Bytes are added as one sum and clamp to all-ones on carry out.
  assign w_bytes_sum  = {1'b0, r_bytes} + (CNT_W + 1)'(w_bytes_add);
  assign w_bytes_next = w_bytes_sum[CNT_W] ? '1 : w_bytes_sum[CNT_W-1:0];

  // Backpressure LFSR, registered in_ready and the packet-tracking FSM.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_ready   <= 1'b0;
      r_exp     <= '0;
      r_beats   <= '0;
      r_pkt_err <= 1'b0;
    end else begin
      r_lfsr  <= {w_lfsr_fb, r_lfsr[15:1]};
      r_ready <= ~bp_en | r_lfsr[0] | r_lfsr[1];
      if (w_acc) begin
        if (in_startofpacket) begin
          if (in_endofpacket) begin
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_INPKT;
            r_exp     <= in_data + 32'd1;
            r_beats   <= BEAT_W'(1);
            r_pkt_err <= in_error;
          end
        end else if (r_state == S_INPKT) begin
          r_exp     <= r_exp + 32'd1;
          if (r_beats != BEATS_MAX) r_beats <= r_beats + BEAT_W'(1);
          r_pkt_err <= r_pkt_err | in_error | w_mismatch | w_overrun;
          if (in_endofpacket) r_state <= S_IDLE;
        end
      end
    end
  end

  // Saturating statistics; clear wins over same-cycle increments.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || clear) begin
      r_good   <= '0;
      r_bad    <= '0;
      r_bytes  <= '0;
      r_fram   <= '0;
      r_data   <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_good   <= sat_inc(r_good, w_good_inc);
      r_bad    <= sat_inc(r_bad,  w_bad_inc);
      r_bytes  <= w_bytes_next;
      r_fram   <= sat_inc(r_fram, w_fram_inc);
      r_data   <= sat_inc(r_data, w_data_inc);
      r_sticky <= r_sticky | w_err_any;
    end
  end

  assign in_ready     = r_ready;
  assign good_pkts    = r_good;
  assign bad_pkts     = r_bad;
  assign rx_bytes     = r_bytes;
  assign framing_errs = r_fram;
  assign data_errs    = r_data;
  assign err_sticky   = r_sticky;

endmodule

// File: tb/tb_avst_pkt_checker.sv
// Directed bench for avst_pkt_checker: a full-width instance and a narrow
// instance (4-bit counters, 4-beat max) share one stimulus stream.
`timescale 1ns/1ps
module tb_avst_pkt_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        in_error = 1'b0;
  logic        bp_en = 1'b0;
  logic        clear = 1'b0;

  logic        ready_a, ready_b;
  logic [31:0] good_a, bad_a, bytes_a, fram_a, data_a;
  logic        sticky_a;
  logic [3:0]  good_b, bad_b, bytes_b, fram_b, data_b;
  logic        sticky_b;

  int errors = 0;
  int checks = 0;
  int unsigned wait_seen = 0;

  logic [15:0] m_lfsr;
  logic        m_ready;

  always #5 clk = ~clk;

  avst_pkt_checker u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_a), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .in_empty(in_empty), .in_error(in_error), .bp_en(bp_en), .clear(clear),
    .good_pkts(good_a), .bad_pkts(bad_a), .rx_bytes(bytes_a),
    .framing_errs(fram_a), .data_errs(data_a), .err_sticky(sticky_a)
  );

  avst_pkt_checker #(.CNT_W(4), .MAX_BEATS(4)) u_small (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_b), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
    .in_empty(in_empty), .in_error(in_error), .bp_en(bp_en), .clear(clear),
    .good_pkts(good_b), .bad_pkts(bad_b), .rx_bytes(bytes_b),
    .framing_errs(fram_b), .data_errs(data_b), .err_sticky(sticky_b)
  );

  // Reference backpressure model: Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_lfsr  <= 16'hACE1;
      m_ready <= 1'b0;
    end else begin
      m_ready <= ~bp_en | m_lfsr[0] | m_lfsr[1];
      m_lfsr  <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic bp);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; bp_en = bp;
    @(negedge clk);
    chk("rst_ready",  {31'd0, ready_a},  32'd0);
    chk("rst_good",   good_a,            32'd0);
    chk("rst_bad",    bad_a,             32'd0);
    chk("rst_bytes",  bytes_a,           32'd0);
    chk("rst_fram",   fram_a,            32'd0);
    chk("rst_data",   data_a,            32'd0);
    chk("rst_sticky", {31'd0, sticky_a}, 32'd0);
    chk("rst_good_s", {28'd0, good_b},   32'd0);
    rst_n = 1'b1;
  endtask

  // One beat: present at a negedge, hold until accepted on a posedge.
  task automatic send(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] em, input logic er, input logic clr);
    int unsigned n = 0;
    @(negedge clk);
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_error = er;
    in_valid = 1'b1; clear = clr;
    while (!ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n != 0) wait_seen++;
    if (n >= 100) chk("accept_timeout", n, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  // Clean incrementing packet; middle beats carry a junk empty that must be ignored.
  task automatic pkt(input logic [31:0] base, input int unsigned n, input logic clr_eop);
    for (int unsigned i = 0; i < n; i++) begin
      send(base + i, i == 0, i == n - 1, (i == n - 1) ? 2'd0 : 2'd2, 1'b0,
           clr_eop && (i == n - 1));
    end
  endtask

  initial begin
    int unsigned acc;
    int unsigned b;
    int unsigned p;
    logic        will;

    // 1) three clean 4-beat packets, no backpressure
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) pkt(32'h10, 4, 1'b0);
    chk("t1_good",  good_a,  32'd3);
    chk("t1_bytes", bytes_a, 32'd48);
    chk("t1_bad",   bad_a,   32'd0);
    chk("t1_fram",  fram_a,  32'd0);
    chk("t1_data",  data_a,  32'd0);
    chk("t1_stky",  {31'd0, sticky_a}, 32'd0);
    chk("t1_wait",  wait_seen, 32'd0);
    chk("t1_good_s",  {28'd0, good_b},  32'd3);
    chk("t1_fram_s",  {28'd0, fram_b},  32'd0);
    chk("t1_bytes_s", {28'd0, bytes_b}, 32'd15);

    // 2) 1-beat packet with empty=3, then EOP empty=2 mismatching only in masked bytes
    do_reset(1'b0);
    send(32'hDEADBEEF, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("t2_bytes1", bytes_a, 32'd1);
    send(32'hA0B00000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'hA0B0BEEF, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("t2_good",  good_a,  32'd2);
    chk("t2_bytes", bytes_a, 32'd7);
    chk("t2_data",  data_a,  32'd0);
    chk("t2_bad",   bad_a,   32'd0);

    // 3) orphan beat, then SOP mid-packet, then the restarted packet ends cleanly
    do_reset(1'b0);
    send(32'h77, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t3_fram1", fram_a, 32'd1);
    chk("t3_stky1", {31'd0, sticky_a}, 32'd1);
    chk("t3_bytes1", bytes_a, 32'd0);
    send(32'h20, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h21, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h50, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t3_fram2", fram_a, 32'd2);
    chk("t3_bad",   bad_a,  32'd1);
    send(32'h51, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h52, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("t3_good",  good_a,  32'd1);
    chk("t3_data",  data_a,  32'd0);
    chk("t3_bytes", bytes_a, 32'd20);
    chk("t3_stky",  {31'd0, sticky_a}, 32'd1);

    // 4) 5 beats, word 3 = exp^1, in_error on EOP; narrow instance also overruns
    do_reset(1'b0);
    send(32'h1000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h1001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h1002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h1002, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t4_data_mid", data_a, 32'd1);
    chk("t4_fram_s",   {28'd0, fram_b}, 32'd1);
    send(32'h1004, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("t4_data",  data_a,  32'd1);
    chk("t4_bad",   bad_a,   32'd1);
    chk("t4_good",  good_a,  32'd0);
    chk("t4_fram",  fram_a,  32'd0);
    chk("t4_bytes", bytes_a, 32'd20);
    chk("t4_bad_s", {28'd0, bad_b}, 32'd1);
    chk("t4_fram_s2", {28'd0, fram_b}, 32'd1);

    // 5) LFSR backpressure, in_valid held high, back-to-back 4-beat packets
    do_reset(1'b1);
    acc = 0; b = 0; p = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("t5_ready", {31'd0, ready_a}, {31'd0, m_ready});
      in_data = (p << 4) + b; in_sop = (b == 0); in_eop = (b == 3);
      in_empty = 2'd0; in_error = 1'b0; in_valid = 1'b1;
      will = ready_a;
      @(posedge clk);
      if (will) begin
        acc++;
        if (b == 3) begin b = 0; p++; end
        else b++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_good",  good_a,  acc / 4);
    chk("t5_bytes", bytes_a, acc * 4);
    chk("t5_bad",   bad_a,   32'd0);
    chk("t5_fram",  fram_a,  32'd0);
    chk("t5_data",  data_a,  32'd0);

    // 6) narrow counters saturate; clear on an EOP beat beats the increment
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) pkt(32'h40 + i, 2, 1'b0);
    chk("t6_good_s",  {28'd0, good_b},  32'd15);
    chk("t6_bytes_s", {28'd0, bytes_b}, 32'd15);
    chk("t6_good",    good_a,  32'd20);
    chk("t6_bytes",   bytes_a, 32'd160);
    pkt(32'h900, 2, 1'b1);
    chk("t6_clr_good_s",  {28'd0, good_b},  32'd0);
    chk("t6_clr_bytes_s", {28'd0, bytes_b}, 32'd0);
    chk("t6_clr_good",    good_a,  32'd0);
    chk("t6_clr_bytes",   bytes_a, 32'd0);
    pkt(32'hA00, 2, 1'b0);
    chk("t6_after_good",  good_a,  32'd1);
    chk("t6_after_bytes", bytes_a, 32'd8);

    // 7) reset mid-packet: the next beat without SOP is an orphan
    do_reset(1'b0);
    send(32'h300, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    send(32'h301, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    do_reset(1'b0);
    send(32'h302, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t7_fram", fram_a, 32'd1);
    chk("t7_data", data_a, 32'd0);
    pkt(32'h400, 3, 1'b0);
    chk("t7_good", good_a, 32'd1);
    chk("t7_bad",  bad_a,  32'd0);

    // 8) 7-beat clean packet: narrow instance flags the overrun exactly once
    do_reset(1'b0);
    pkt(32'h5000, 7, 1'b0);
    chk("t8_fram_s", {28'd0, fram_b}, 32'd1);
    chk("t8_bad_s",  {28'd0, bad_b},  32'd1);
    chk("t8_good_s", {28'd0, good_b}, 32'd0);
    chk("t8_good",   good_a, 32'd1);
    chk("t8_fram",   fram_a, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
